// File: rtl/ctrl_2mhz.sv
// Read-domain controller for the temperature-packet path: drains FIFO bytes,
// averages each group of four and writes the result to packet RAM, top-down.
//   state | meaning
//   IDLE  | wait for FIFO not empty (only place fifo_empty is looked at)
//   RD    | single-cycle FIFO read strobe
//   CAP   | registered FIFO data valid; accumulate, or finish the group
//   WR    | single-cycle RAM write, address/data stable
//   DEC   | step RAM address down, wrapping to START_ADDR
module ctrl_2mhz #(
    parameter int          ADDR_W     = 11,
    parameter int unsigned START_ADDR = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_rd_data,
    output logic              fifo_rd,
    output logic              ram_wr_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [1:0]        byte_cnt
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DEC
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        acc_q, acc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [9:0]        sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= START;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum     = acc_q + {2'b00, fifo_rd_data};
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_RD;
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (cnt_q == 2'd3) begin
                    // Truncating divide by four of the full 10-bit group sum
                    data_d  = sum[9:2];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_WR;
                end else begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                state_d = S_DEC;
            end
            S_DEC: begin
                addr_d  = (addr_q == '0) ? START : addr_q - ADDR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode registered state only, so reset releases them at once
    assign fifo_rd  = (state_q == S_RD);
    assign ram_wr_n = (state_q != S_WR);
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign byte_cnt = cnt_q;

endmodule
